// File: rtl/branch_predictor_btb_if.sv
// Decode/Execute signal bundle between the pipeline and the branch predictor.
// The pipeline side is the master; the predictor itself is the slave.
interface branch_predictor_btb_if #(
  parameter int INDEX_BITS = 6
);
  // Decode-stage lookup
  logic [31:0]           PCD;
  logic                  BranchD;
  logic                  TakenD;
  logic [31:0]           PredPCD;
  logic [INDEX_BITS-1:0] IdxD;

  // Execute-stage resolution and training
  logic                  BranchE;
  logic [31:0]           PCE;
  logic [INDEX_BITS-1:0] IdxE;
  logic                  PredTakenE;
  logic [31:0]           PredPCE;
  logic                  ActualTakenE;
  logic [31:0]           PCTargetE;
  logic                  MispredictE;
  logic [31:0]           CorrectPCE;
  logic                  FlushD_BP;
  logic                  FlushE_BP;

  // Performance counters
  logic [31:0]           BranchCount;
  logic [31:0]           MispredictCount;

  modport master (
    output PCD, BranchD, BranchE, PCE, IdxE, PredTakenE, PredPCE,
           ActualTakenE, PCTargetE,
    input  TakenD, PredPCD, IdxD, MispredictE, CorrectPCE, FlushD_BP,
           FlushE_BP, BranchCount, MispredictCount
  );

  modport slave (
    input  PCD, BranchD, BranchE, PCE, IdxE, PredTakenE, PredPCE,
           ActualTakenE, PCTargetE,
    output TakenD, PredPCD, IdxD, MispredictE, CorrectPCE, FlushD_BP,
           FlushE_BP, BranchCount, MispredictCount
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Branch predictor: 2-bit saturating counters plus a tagged branch target
// buffer, indexed by PC optionally hashed (XOR) with a non-speculative global
// history register. Lookup in Decode is combinational; training happens in
// Execute on the clock edge, so a same-cycle lookup sees pre-update state.
module branch_predictor_btb #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8,
  parameter int GHR_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_predictor_btb_if.slave bp
);
  localparam int ENTRIES = 2 ** INDEX_BITS;
  // In bimodal mode the history register is one bit wide and held at zero.
  localparam int GHR_W   = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;

  logic [1:0]          ctr_reg    [ENTRIES];
  logic [ENTRIES-1:0]  valid_reg;
  logic [TAG_BITS-1:0] tag_reg    [ENTRIES];
  logic [31:0]         target_reg [ENTRIES];
  logic [GHR_W-1:0]    ghr_reg;
  logic [31:0]         branch_count_reg;
  logic [31:0]         mispredict_count_reg;

  logic [INDEX_BITS-1:0] idx_d;
  logic [TAG_BITS-1:0]   tag_d;
  logic [TAG_BITS-1:0]   tag_e;
  logic                  taken_d;
  logic                  mispredict_e;
  logic [1:0]            ctr_next;
  logic [GHR_W-1:0]      ghr_next;
  logic                  unused_pc_bits;

  // Only a slice of each PC feeds index/tag; fold the rest into a sink.
  assign unused_pc_bits = ^{bp.PCD, bp.PCE};

  // Decode lookup: index hash, tag compare and prediction
  always_comb begin
    idx_d   = bp.PCD[INDEX_BITS+1:2] ^ INDEX_BITS'(ghr_reg);
    tag_d   = bp.PCD[TAG_HI:TAG_LO];
    taken_d = bp.BranchD & valid_reg[idx_d] & (tag_reg[idx_d] == tag_d)
              & ctr_reg[idx_d][1];
  end

  assign bp.IdxD    = idx_d;
  assign bp.TakenD  = taken_d;
  assign bp.PredPCD = taken_d ? target_reg[idx_d] : bp.PCD + 32'd4;

  // Execute resolution: mispredict detection and redirect target
  always_comb begin
    mispredict_e = bp.BranchE &
                   ((bp.PredTakenE != bp.ActualTakenE) |
                    (bp.PredTakenE & bp.ActualTakenE & (bp.PredPCE != bp.PCTargetE)));
    tag_e        = bp.PCE[TAG_HI:TAG_LO];
    ghr_next     = (GHR_BITS == 0) ? '0 : GHR_W'({ghr_reg, bp.ActualTakenE});
    ctr_next     = ctr_reg[bp.IdxE];
    if (bp.ActualTakenE) begin
      if (ctr_reg[bp.IdxE] != 2'b11) ctr_next = ctr_reg[bp.IdxE] + 2'b01;
    end else begin
      if (ctr_reg[bp.IdxE] != 2'b00) ctr_next = ctr_reg[bp.IdxE] - 2'b01;
    end
  end

  assign bp.MispredictE     = mispredict_e;
  assign bp.CorrectPCE      = bp.ActualTakenE ? bp.PCTargetE : bp.PCE + 32'd4;
  assign bp.FlushD_BP       = mispredict_e;
  assign bp.FlushE_BP       = mispredict_e;
  assign bp.BranchCount     = branch_count_reg;
  assign bp.MispredictCount = mispredict_count_reg;

  // Training on resolved branches; reset wipes predictions but not the
  // tag/target payload, which is meaningless once the valid bit is clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_reg[i] <= 2'b01;
      end
      valid_reg            <= '0;
      ghr_reg              <= '0;
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else if (bp.BranchE) begin
      ctr_reg[bp.IdxE] <= ctr_next;
      if (bp.ActualTakenE) begin
        valid_reg[bp.IdxE]  <= 1'b1;
        tag_reg[bp.IdxE]    <= tag_e;
        target_reg[bp.IdxE] <= bp.PCTargetE;
      end
      ghr_reg <= ghr_next;
      if (branch_count_reg != 32'hFFFF_FFFF) begin
        branch_count_reg <= branch_count_reg + 32'd1;
      end
      if (mispredict_e && (mispredict_count_reg != 32'hFFFF_FFFF)) begin
        mispredict_count_reg <= mispredict_count_reg + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed scenarios on a bimodal instance,
// randomized traffic on a gshare instance against a table-level model.
module tb_branch_predictor_btb;
  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  branch_predictor_btb_if #(.INDEX_BITS(6)) b0 ();
  branch_predictor_btb_if #(.INDEX_BITS(6)) b1 ();

  branch_predictor_btb #(.INDEX_BITS(6), .TAG_BITS(8), .GHR_BITS(0)) dut_bimodal (
    .clk(clk), .reset(reset), .bp(b0.slave)
  );
  branch_predictor_btb #(.INDEX_BITS(6), .TAG_BITS(8), .GHR_BITS(4)) dut_gshare (
    .clk(clk), .reset(reset), .bp(b1.slave)
  );

  // Reference model state for the gshare instance
  int          m_cnt   [64];
  bit          m_valid [64];
  int unsigned m_tag   [64];
  logic [31:0] m_tgt   [64];
  int unsigned m_ghr;
  int unsigned m_bc;
  int unsigned m_mc;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return ((pc / 4) % 64) ^ (m_ghr % 16);
  endfunction

  function automatic int unsigned tag_of(input logic [31:0] pc);
    return (pc / 256) % 256;
  endfunction

  // Drive the Execute side of the bimodal instance
  task automatic set_e0(input bit br, input logic [31:0] pc, input bit pt,
                        input logic [31:0] ppc, input bit at, input logic [31:0] tgt);
    b0.BranchE      = br;
    b0.PCE          = pc;
    b0.IdxE         = pc[7:2];
    b0.PredTakenE   = pt;
    b0.PredPCE      = ppc;
    b0.ActualTakenE = at;
    b0.PCTargetE    = tgt;
  endtask

  task automatic idle_all();
    set_e0(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    b0.PCD = 32'h0; b0.BranchD = 1'b0;
    b1.PCD = 32'h0; b1.BranchD = 1'b0; b1.BranchE = 1'b0; b1.PCE = 32'h0;
    b1.IdxE = '0; b1.PredTakenE = 1'b0; b1.PredPCE = 32'h0;
    b1.ActualTakenE = 1'b0; b1.PCTargetE = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    b0.PCD = 32'h14; b0.BranchD = 1'b1;
    reset = 1'b0;
    #1;
    $display("[TB] reset: PCD=%h TakenD=%0b PredPCD=%h", b0.PCD, b0.TakenD, b0.PredPCD);
    tests_run++;
    if (b0.TakenD !== 1'b0) begin tests_failed++; $display("FAIL reset_taken: got %0b want 0", b0.TakenD); end
    tests_run++;
    if (b0.PredPCD !== 32'h18) begin tests_failed++; $display("FAIL reset_predpc: got %h want 00000018", b0.PredPCD); end
    tests_run++;
    if (b0.BranchCount !== 32'd0 || b0.MispredictCount !== 32'd0) begin
      tests_failed++; $display("FAIL reset_counts: got %0d/%0d want 0/0", b0.BranchCount, b0.MispredictCount);
    end
  endtask

  task automatic test_train();
    @(negedge clk);
    set_e0(1'b1, 32'h14, 1'b0, 32'h18, 1'b1, 32'h40);
    #1;
    $display("[TB] train1: MispredictE=%0b CorrectPCE=%h", b0.MispredictE, b0.CorrectPCE);
    tests_run++;
    if (b0.MispredictE !== 1'b1 || b0.CorrectPCE !== 32'h40) begin
      tests_failed++; $display("FAIL train1: got mis=%0b cpc=%h want 1/00000040", b0.MispredictE, b0.CorrectPCE);
    end
    @(negedge clk);
    set_e0(1'b1, 32'h14, 1'b1, 32'h40, 1'b1, 32'h40);
    #1;
    $display("[TB] train2: MispredictE=%0b TakenD=%0b", b0.MispredictE, b0.TakenD);
    tests_run++;
    if (b0.MispredictE !== 1'b0 || b0.TakenD !== 1'b1) begin
      tests_failed++; $display("FAIL train2: got mis=%0b taken=%0b want 0/1", b0.MispredictE, b0.TakenD);
    end
    @(negedge clk);
    set_e0(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    $display("[TB] train_lookup: TakenD=%0b PredPCD=%h BC=%0d MC=%0d",
             b0.TakenD, b0.PredPCD, b0.BranchCount, b0.MispredictCount);
    tests_run++;
    if (b0.TakenD !== 1'b1 || b0.PredPCD !== 32'h40) begin
      tests_failed++; $display("FAIL train_lookup: got taken=%0b pc=%h want 1/00000040", b0.TakenD, b0.PredPCD);
    end
    tests_run++;
    if (b0.BranchCount !== 32'd2 || b0.MispredictCount !== 32'd1) begin
      tests_failed++; $display("FAIL train_counts: got %0d/%0d want 2/1", b0.BranchCount, b0.MispredictCount);
    end
  endtask

  task automatic test_mispredict_not_taken();
    @(negedge clk);
    set_e0(1'b1, 32'h14, 1'b1, 32'h40, 1'b0, 32'h40);
    #1;
    $display("[TB] mis_nt: MispredictE=%0b FlushD=%0b FlushE=%0b CorrectPCE=%h",
             b0.MispredictE, b0.FlushD_BP, b0.FlushE_BP, b0.CorrectPCE);
    tests_run++;
    if ({b0.MispredictE, b0.FlushD_BP, b0.FlushE_BP} !== 3'b111 || b0.CorrectPCE !== 32'h18) begin
      tests_failed++;
      $display("FAIL mis_nt: got mis/fd/fe=%0b%0b%0b cpc=%h want 111/00000018",
               b0.MispredictE, b0.FlushD_BP, b0.FlushE_BP, b0.CorrectPCE);
    end
    @(negedge clk);
    set_e0(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    $display("[TB] mis_nt_after: TakenD=%0b BC=%0d MC=%0d", b0.TakenD, b0.BranchCount, b0.MispredictCount);
    tests_run++;
    if (b0.TakenD !== 1'b1 || b0.BranchCount !== 32'd3 || b0.MispredictCount !== 32'd2) begin
      tests_failed++;
      $display("FAIL mis_nt_after: got taken=%0b bc=%0d mc=%0d want 1/3/2", b0.TakenD, b0.BranchCount, b0.MispredictCount);
    end
  endtask

  task automatic test_target_change();
    @(negedge clk);
    set_e0(1'b1, 32'h14, 1'b1, 32'h40, 1'b1, 32'h80);
    #1;
    $display("[TB] retarget: MispredictE=%0b CorrectPCE=%h", b0.MispredictE, b0.CorrectPCE);
    tests_run++;
    if (b0.MispredictE !== 1'b1 || b0.CorrectPCE !== 32'h80) begin
      tests_failed++; $display("FAIL retarget: got mis=%0b cpc=%h want 1/00000080", b0.MispredictE, b0.CorrectPCE);
    end
    @(negedge clk);
    set_e0(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    $display("[TB] retarget_lookup: TakenD=%0b PredPCD=%h MC=%0d", b0.TakenD, b0.PredPCD, b0.MispredictCount);
    tests_run++;
    if (b0.TakenD !== 1'b1 || b0.PredPCD !== 32'h80 || b0.MispredictCount !== 32'd3) begin
      tests_failed++;
      $display("FAIL retarget_lookup: got taken=%0b pc=%h mc=%0d want 1/00000080/3", b0.TakenD, b0.PredPCD, b0.MispredictCount);
    end
  endtask

  task automatic test_alias();
    @(negedge clk);
    b0.PCD = 32'h114; b0.BranchD = 1'b1;
    #1;
    $display("[TB] alias: PCD=%h IdxD=%0d TakenD=%0b PredPCD=%h", b0.PCD, b0.IdxD, b0.TakenD, b0.PredPCD);
    tests_run++;
    if (b0.IdxD !== 6'd5 || b0.TakenD !== 1'b0 || b0.PredPCD !== 32'h118) begin
      tests_failed++;
      $display("FAIL alias: got idx=%0d taken=%0b pc=%h want 5/0/00000118", b0.IdxD, b0.TakenD, b0.PredPCD);
    end
    b0.PCD = 32'h14;
  endtask

  task automatic test_same_cycle();
    // Entry 5 starts at the strongest taken state here.
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      b0.PCD = 32'h14; b0.BranchD = 1'b1;
      set_e0(1'b1, 32'h14, 1'b1, 32'h80, 1'b0, 32'h80);
      #1;
      $display("[TB] same_cycle%0d: TakenD=%0b PredPCD=%h", k, b0.TakenD, b0.PredPCD);
      tests_run++;
      if (b0.TakenD !== 1'b1 || b0.PredPCD !== 32'h80) begin
        tests_failed++; $display("FAIL same_cycle%0d: got taken=%0b pc=%h want 1/00000080", k, b0.TakenD, b0.PredPCD);
      end
    end
    @(negedge clk);
    set_e0(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    $display("[TB] same_cycle_after: TakenD=%0b PredPCD=%h", b0.TakenD, b0.PredPCD);
    tests_run++;
    if (b0.TakenD !== 1'b0 || b0.PredPCD !== 32'h18) begin
      tests_failed++; $display("FAIL same_cycle_after: got taken=%0b pc=%h want 0/00000018", b0.TakenD, b0.PredPCD);
    end
  endtask

  task automatic test_no_update();
    @(negedge clk);
    set_e0(1'b0, 32'h14, 1'b0, 32'h0, 1'b1, 32'h40);
    @(negedge clk);
    set_e0(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    $display("[TB] no_update: TakenD=%0b BC=%0d MC=%0d", b0.TakenD, b0.BranchCount, b0.MispredictCount);
    tests_run++;
    if (b0.TakenD !== 1'b0 || b0.BranchCount !== 32'd6 || b0.MispredictCount !== 32'd5) begin
      tests_failed++;
      $display("FAIL no_update: got taken=%0b bc=%0d mc=%0d want 0/6/5", b0.TakenD, b0.BranchCount, b0.MispredictCount);
    end
  endtask

  task automatic test_reset_midrun();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_e0(1'b1, 32'h14, 1'b1, 32'h80, 1'b1, 32'h80);
    end
    @(negedge clk);
    set_e0(1'b1, 32'h14, 1'b1, 32'h80, 1'b1, 32'h80);
    b0.PCD = 32'h14; b0.BranchD = 1'b1;
    #1;
    tests_run++;
    if (b0.TakenD !== 1'b1) begin tests_failed++; $display("FAIL midrun_pre: got taken=%0b want 1", b0.TakenD); end
    #1 reset = 1'b1;
    #1;
    $display("[TB] midrun_reset: TakenD=%0b PredPCD=%h BC=%0d MC=%0d",
             b0.TakenD, b0.PredPCD, b0.BranchCount, b0.MispredictCount);
    tests_run++;
    if (b0.TakenD !== 1'b0 || b0.PredPCD !== 32'h18) begin
      tests_failed++; $display("FAIL midrun_reset: got taken=%0b pc=%h want 0/00000018", b0.TakenD, b0.PredPCD);
    end
    tests_run++;
    if (b0.BranchCount !== 32'd0 || b0.MispredictCount !== 32'd0) begin
      tests_failed++; $display("FAIL midrun_counts: got %0d/%0d want 0/0", b0.BranchCount, b0.MispredictCount);
    end
    @(negedge clk);
    reset = 1'b0;
    set_e0(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    $display("[TB] midrun_release: TakenD=%0b BC=%0d", b0.TakenD, b0.BranchCount);
    tests_run++;
    if (b0.TakenD !== 1'b0 || b0.BranchCount !== 32'd0) begin
      tests_failed++; $display("FAIL midrun_release: got taken=%0b bc=%0d want 0/0", b0.TakenD, b0.BranchCount);
    end
  endtask

  task automatic test_random_gshare();
    logic [31:0] pcd, pce, tgt, ppc, exp_ppc, exp_cpc;
    bit          bd, be, pt, at, exp_t, exp_mis;
    int unsigned i, ie;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 64; k++) begin
      m_cnt[k] = 1; m_valid[k] = 1'b0; m_tag[k] = 0; m_tgt[k] = 32'h0;
    end
    m_ghr = 0; m_bc = 0; m_mc = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      pcd = 32'h100 * $urandom_range(0, 3) + 4 * $urandom_range(0, 15);
      pce = 32'h100 * $urandom_range(0, 3) + 4 * $urandom_range(0, 15);
      tgt = $urandom & 32'hFFFF_FFFC;
      ppc = ($urandom_range(0, 1) == 1) ? tgt : ($urandom & 32'hFFFF_FFFC);
      bd  = ($urandom_range(0, 3) != 0);
      be  = ($urandom_range(0, 3) != 0);
      pt  = $urandom_range(0, 1);
      at  = ($urandom_range(0, 3) != 0);
      ie  = idx_of(pce);
      b1.PCD = pcd; b1.BranchD = bd; b1.BranchE = be; b1.PCE = pce;
      b1.IdxE = ie[5:0]; b1.PredTakenE = pt; b1.PredPCE = ppc;
      b1.ActualTakenE = at; b1.PCTargetE = tgt;
      #1;
      i       = idx_of(pcd);
      exp_t   = bd && m_valid[i] && (m_tag[i] == tag_of(pcd)) && (m_cnt[i] >= 2);
      exp_ppc = exp_t ? m_tgt[i] : pcd + 32'd4;
      exp_mis = be && ((pt != at) || (pt && at && ppc != tgt));
      exp_cpc = at ? tgt : pce + 32'd4;
      $display("[TB] rnd %0d: pcd=%h taken=%0b pred=%h mis=%0b cpc=%h bc=%0d",
               n, pcd, b1.TakenD, b1.PredPCD, b1.MispredictE, b1.CorrectPCE, b1.BranchCount);
      tests_run++;
      if (b1.TakenD !== exp_t || b1.PredPCD !== exp_ppc || b1.IdxD !== i[5:0]) begin
        tests_failed++;
        $display("FAIL rnd_lookup %0d: got taken=%0b pc=%h idx=%0d want %0b/%h/%0d",
                 n, b1.TakenD, b1.PredPCD, b1.IdxD, exp_t, exp_ppc, i);
      end
      tests_run++;
      if (b1.MispredictE !== exp_mis || b1.FlushD_BP !== exp_mis || b1.FlushE_BP !== exp_mis ||
          b1.CorrectPCE !== exp_cpc) begin
        tests_failed++;
        $display("FAIL rnd_resolve %0d: got mis=%0b cpc=%h want %0b/%h", n, b1.MispredictE, b1.CorrectPCE, exp_mis, exp_cpc);
      end
      tests_run++;
      if (b1.BranchCount !== m_bc || b1.MispredictCount !== m_mc) begin
        tests_failed++;
        $display("FAIL rnd_counts %0d: got %0d/%0d want %0d/%0d", n, b1.BranchCount, b1.MispredictCount, m_bc, m_mc);
      end
      // Model the coming clock edge
      if (be) begin
        m_cnt[ie] = at ? ((m_cnt[ie] < 3) ? m_cnt[ie] + 1 : 3) : ((m_cnt[ie] > 0) ? m_cnt[ie] - 1 : 0);
        if (at) begin
          m_valid[ie] = 1'b1; m_tag[ie] = tag_of(pce); m_tgt[ie] = tgt;
        end
        m_ghr = (m_ghr * 2 + (at ? 1 : 0)) % 16;
        m_bc++;
        if (exp_mis) m_mc++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle_all();
    test_reset();
    test_train();
    test_mispredict_not_taken();
    test_target_change();
    test_alias();
    test_same_cycle();
    test_no_update();
    test_reset_midrun();
    test_random_gshare();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
